// File: rtl/wrr_vchannel_arbiter_if.sv
// Bundle between the virtual-channel FIFOs, the WRR arbiter and the output link.
// The arbiter uses the slave modport; the FIFO/link side uses master.
interface wrr_vchannel_arbiter_if #(
    parameter int NCH = 4,
    parameter int DW  = 4,
    parameter int WW  = 3,
    parameter int PW  = 2
);
    logic                enb;
    logic [NCH-1:0]      empty_i;
    logic [NCH*DW-1:0]   data_i;
    logic [NCH*WW-1:0]   weight_i;
    logic [NCH-1:0]      pop_o;
    logic [DW-1:0]       data_o;
    logic                valid_o;
    logic [PW-1:0]       grant_o;

    modport master (
        output enb, empty_i, data_i, weight_i,
        input  pop_o, data_o, valid_o, grant_o
    );

    modport slave (
        input  enb, empty_i, data_i, weight_i,
        output pop_o, data_o, valid_o, grant_o
    );
endinterface

// File: rtl/wrr_vchannel_arbiter.sv
// Weighted round-robin arbiter/mux: N first-word-fall-through FIFOs onto one link.
// Optional macro WRR_STRICT_PRIO_EN makes channel 0 strict priority outside the WRR.
module wrr_vchannel_arbiter #(
    parameter int            NCH       = 4,
    parameter int            DW        = 4,
    parameter int            WW        = 3,
    parameter int            PW        = 2,
    parameter logic [DW-1:0] IDLE_WORD = '0
) (
    input logic                  clk,
    input logic                  rst,
    wrr_vchannel_arbiter_if.slave bus
);

    logic [PW-1:0]  r_ptr;
    logic [WW-1:0]  r_credit;
    logic [DW-1:0]  r_data;
    logic           r_valid;
    logic [PW-1:0]  r_grant;

    logic [NCH-1:0] w_elig;
    logic           w_found;
    logic [PW-1:0]  w_sidx;
    logic           w_stay;
    logic           w_gnt;
    logic [PW-1:0]  w_gidx;
    logic [PW-1:0]  w_nptr;
    logic [WW-1:0]  w_ncredit;
    logic [WW-1:0]  w_sweight;
    logic [DW-1:0]  w_gdata;
    logic [NCH-1:0] w_pop;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_elig[i] = !bus.empty_i[i] && (bus.weight_i[i*WW +: WW] != '0);
        end
`ifdef WRR_STRICT_PRIO_EN
        w_elig[0] = 1'b0;
`endif
    end

    // Circular scan starting just after the pointer and ending on the pointer itself.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_sidx  = r_ptr;
        idx     = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_sidx  = PW'(idx);
            end
        end
    end

    assign w_sweight = bus.weight_i[int'(w_sidx)*WW +: WW];
    assign w_stay    = (r_credit != '0) && !bus.empty_i[r_ptr];

    always_comb begin
        w_gnt     = 1'b0;
        w_gidx    = r_ptr;
        w_nptr    = r_ptr;
        w_ncredit = r_credit;
        if (bus.enb) begin
`ifdef WRR_STRICT_PRIO_EN
            if (!bus.empty_i[0]) begin
                w_gnt  = 1'b1;
                w_gidx = '0;
            end else
`endif
            if (w_stay) begin
                w_gnt     = 1'b1;
                w_ncredit = r_credit - WW'(1);
            end else if (w_found) begin
                w_gnt     = 1'b1;
                w_gidx    = w_sidx;
                w_nptr    = w_sidx;
                w_ncredit = w_sweight - WW'(1);
            end else begin
                w_ncredit = '0;
            end
        end
    end

    // Pop strobe is suppressed while reset is held so FIFOs are never drained in reset.
    always_comb begin
        w_pop = '0;
        if (w_gnt && rst) w_pop[w_gidx] = 1'b1;
    end

    assign w_gdata = bus.data_i[int'(w_gidx)*DW +: DW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr    <= PW'(NCH-1);
            r_credit <= '0;
            r_data   <= IDLE_WORD;
            r_valid  <= 1'b0;
            r_grant  <= '0;
        end else if (bus.enb) begin
            r_valid  <= w_gnt;
            r_ptr    <= w_nptr;
            r_credit <= w_ncredit;
            if (w_gnt) begin
                r_data  <= w_gdata;
                r_grant <= w_gidx;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign bus.pop_o   = w_pop;
    assign bus.data_o  = r_data;
    assign bus.valid_o = r_valid;
    assign bus.grant_o = r_grant;

endmodule

// File: doc/wrr_vchannel_arbiter.md
Name: wrr_vchannel_arbiter

Overview:
- Parametrised weighted round-robin arbiter and mux for N virtual-channel FIFOs feeding a single output link.
- Each enabled cycle it selects one non-empty channel according to per-channel weights (credits), pops it, and registers its word onto the output with a valid flag.
- It sits between the virtual-channel FIFOs (first-word-fall-through) and the downstream link or demux.

Parameters:
- NCH, 4, number of virtual channels (2..16).
- DW, 4, data word width in bits.
- WW, 3, width of each weight field; weight range 0..2^WW-1.
- PW, 2, pointer width; must equal ceil(log2(NCH)).
- IDLE_WORD, 0, value driven on data_o after reset.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- enb  in  1  arbitration enable.
- empty_i  in  NCH  per-channel FIFO empty; bit i belongs to channel i.
- data_i  in  NCH*DW  FIFO head words; channel i occupies bits [i*DW +: DW].
- weight_i  in  NCH*WW  per-channel weights, same packing as data_i.
- pop_o  out  NCH  one-hot FIFO read strobe; combinational, same cycle as the grant.
- data_o  out  DW  registered output word.
- valid_o  out  1  registered; data_o carries a popped word this cycle.
- grant_o  out  PW  registered index of the channel that produced data_o.

Behaviour:
- Reset (rst=0, asynchronous):
  - data_o=IDLE_WORD, valid_o=0, grant_o=0.
  - Internal state: ptr=NCH-1, credit=0.
  - pop_o=0 while rst=0.
  - Reset mid-burst discards any remaining credit. The first search after release starts at channel 0.
- Eligible channel: empty_i[i]=0 and weight[i]!=0. A weight of 0 masks the channel.
- Grant decision, combinational, evaluated only when enb=1:
  - Stay: if credit>0 and channel ptr is non-empty, grant ptr; next credit=credit-1.
  - Search: otherwise scan ptr+1, ptr+2, … circularly (modulo NCH), ending with ptr itself. Grant the first eligible channel g; next ptr=g; next credit=weight[g]-1.
  - No grant: if no channel is eligible, there is no grant, pop_o=0, and credit is cleared to 0.
- On a grant to channel g:
  - pop_o[g]=1 in the same cycle.
  - Next edge: data_o<=data_i[g], grant_o<=g, valid_o<=1.
  - Latency from pop to valid_o is one cycle.
- No grant with enb=1: valid_o<=0; data_o and grant_o hold.
- enb=0: pop_o=0, valid_o<=0; data_o, grant_o, ptr and credit hold.
- Weights are sampled only at a search reload. A change mid-burst takes effect at the next reload.
- A channel that goes empty mid-burst forfeits its remaining credit. The next eligible channel is granted in that same cycle, with no idle bubble.
- With a single eligible channel, it is granted every enabled cycle.
- At most one pop_o bit is high in any cycle.
- Credit counter is WW bits wide and never underflows: it is decremented only when >0 and reloaded with weight-1.

Optional Feature:
- Macro: WRR_STRICT_PRIO_EN.
- Defined:
  - Channel 0 is strict priority. Whenever empty_i[0]=0 and enb=1, channel 0 is granted regardless of ptr, credit or weight[0].
  - ptr and credit hold during such grants. The interrupted round-robin burst resumes afterwards with its remaining credit.
  - Channel 0 is excluded from the weighted search.
- Not defined: channel 0 is an ordinary weighted channel as above.

Test Plan:
- Reset check: rst=0 mid-traffic -> immediately data_o=0, valid_o=0, pop_o=0, grant_o=0. After release with all channels full and weights {1,1,1,1}, the first grant is channel 0.
- Weighted order: NCH=4, weights {3,1,2,1}, all non-empty, enb=1 -> grant_o sequence 0,0,0,1,2,2,3,0,0,0…, one cycle after the matching pop_o. data_o equals the channel's head word.
- Mid-burst empty: weights {3,1,1,1}, channel 0 goes empty after 1 pop -> the next cycle grants channel 1 with no idle cycle. valid_o stays 1.
- Mask and idle: weights {0,2,0,0}, all non-empty -> only channel 1 is granted, every cycle. Then all empty_i=1 -> pop_o=0, valid_o=0, data_o holds its last word.
- enb gating: enb=0 for 3 cycles during a burst of weight 3 after 1 grant -> no pops, valid_o=0. On re-enable, 2 more grants go to the same channel before it advances.
- Strict priority (WRR_STRICT_PRIO_EN defined): weights {1,2,2,2}, channel 0 becomes non-empty during a channel-2 burst -> channel 0 is granted immediately, then channel 2 completes its remaining credit.
